// File: rtl/sass_pkg.sv
// -----------------------------------------------------------------------------
// sass_pkg
// Shared constants and types for the sass_synth input path.
//   - CLK_HZ / DEB_MS / DEB_CYCLES_DEFAULT : debounce timing at 12 MHz
//   - db_state_t                           : per-button debounce FSM states
//   - PB_* indices                         : control-button positions in pb
//   - lowest_idx()                         : lowest-set-bit encoder for keys
// -----------------------------------------------------------------------------
package sass_pkg;

   localparam int CLK_HZ             = 12_000_000;
   localparam int DEB_MS             = 10;
   localparam int DEB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEB_MS;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;

   // Control buttons sit above the 15 piano keys.
   localparam int PB_CS    = 15;
   localparam int PB_RST   = 16;
   localparam int PB_PLAY  = 17;
   localparam int PB_POWER = 18;
   localparam int PB_TEMPO = 19;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/pb_debounce_bit.sv
// -----------------------------------------------------------------------------
// pb_debounce_bit
// One button: 2-flop synchroniser, then a STABLE/PENDING debounce FSM that
// accepts a new level only after DEB_CYCLES consecutive disagreeing samples.
// Ports:
//   hwclk  in  system clock
//   n_rst  in  synchronous active-low reset
//   raw    in  asynchronous raw button input
//   level  out debounced level
//   rise   out one-cycle pulse coincident with level 0->1
//   fall   out one-cycle pulse coincident with level 1->0
// -----------------------------------------------------------------------------
module pb_debounce_bit
   import sass_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic hwclk,
   input  logic n_rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW   = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic          s1;
   logic          s2;
   db_state_t     state;
   logic [CW-1:0] count;

   // Synchroniser, debounce FSM and registered level/pulse outputs.
   always_ff @(posedge hwclk) begin
      if (!n_rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= DB_STABLE;
         count <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            DB_STABLE: begin
               if (s2 != level) begin
                  // A single required sample means the first mismatch is accepted.
                  if (DEB_CYCLES == 1) begin
                     level <= s2;
                     rise  <= s2;
                     fall  <= ~s2;
                     count <= '0;
                  end else begin
                     state <= DB_PENDING;
                     count <= ONE;
                  end
               end else begin
                  count <= '0;
               end
            end
            DB_PENDING: begin
               if (s2 == level) begin
                  // Bounce back to the old level: abandon the candidate.
                  state <= DB_STABLE;
                  count <= '0;
               end else if (count == LAST) begin
                  level <= s2;
                  rise  <= s2;
                  fall  <= ~s2;
                  state <= DB_STABLE;
                  count <= '0;
               end else begin
                  count <= count + ONE;
               end
            end
            default: begin
               state <= DB_STABLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
// Conditions WIDTH raw push-buttons for the synth core: per-bit sync+debounce,
// clean levels with rise/fall pulses, a registered lowest-index piano-key
// encoder and optional latch-style toggle outputs.
// Optional feature macro: PB_TOGGLE_EN (toggle flops on TOGGLE_MASK bits;
// without it pb_toggle is constant zero).
// Ports:
//   hwclk     in  system clock
//   n_rst     in  synchronous active-low reset
//   pb_raw    in  [WIDTH] raw active-high buttons
//   pb_level  out [WIDTH] debounced levels
//   pb_rise   out [WIDTH] one-cycle rise pulses
//   pb_fall   out [WIDTH] one-cycle fall pulses
//   key_valid out any piano key held (trails pb_level by one cycle)
//   key_idx   out [4] lowest held piano key, 0 when none
//   pb_toggle out [WIDTH] toggle state per masked bit
// -----------------------------------------------------------------------------
module pb_conditioner
   import sass_pkg::*;
#(
   parameter int               WIDTH       = 20,
   parameter int               NKEYS       = 15,
   parameter int               DEB_CYCLES  = DEB_CYCLES_DEFAULT,
   parameter logic [WIDTH-1:0] TOGGLE_MASK = {WIDTH{1'b0}}
) (
   input  logic             hwclk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] pb_raw,
   output logic [WIDTH-1:0] pb_level,
   output logic [WIDTH-1:0] pb_rise,
   output logic [WIDTH-1:0] pb_fall,
   output logic             key_valid,
   output logic [3:0]       key_idx,
   output logic [WIDTH-1:0] pb_toggle
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      pb_debounce_bit #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .hwclk(hwclk),
         .n_rst(n_rst),
         .raw  (pb_raw[g]),
         .level(pb_level[g]),
         .rise (pb_rise[g]),
         .fall (pb_fall[g])
      );
   end

   logic [15:0] keys;

   // Zero-extend the piano-key slice to the encoder's 16-bit input.
   always_comb begin
      keys              = 16'h0000;
      keys[NKEYS-1:0]   = pb_level[NKEYS-1:0];
   end

   // Registered key encoder.
   always_ff @(posedge hwclk) begin
      if (!n_rst) begin
         key_valid <= 1'b0;
         key_idx   <= 4'd0;
      end else begin
         key_valid <= |keys;
         key_idx   <= lowest_idx(keys);
      end
   end

`ifdef PB_TOGGLE_EN
   logic [WIDTH-1:0] toggle_q;

   // Latch-style toggles: unmasked bits never change from 0.
   always_ff @(posedge hwclk) begin
      if (!n_rst) begin
         toggle_q <= {WIDTH{1'b0}};
      end else begin
         toggle_q <= toggle_q ^ (pb_rise & TOGGLE_MASK);
      end
   end

   assign pb_toggle = toggle_q;
`else
   assign pb_toggle = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pb_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pb_conditioner
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares after every clock edge. Directed
// scenarios add latency/priority checks, then a random phase follows.
// -----------------------------------------------------------------------------
module tb_pb_conditioner;

   localparam int               W    = 20;
   localparam int               NK   = 15;
   localparam int               DEB  = 4;
   localparam logic [W-1:0]     MASK = 20'h40000;

   logic          hwclk;
   logic          n_rst;
   logic [W-1:0]  pb_raw;
   logic [W-1:0]  pb_level;
   logic [W-1:0]  pb_rise;
   logic [W-1:0]  pb_fall;
   logic          key_valid;
   logic [3:0]    key_idx;
   logic [W-1:0]  pb_toggle;

   pb_conditioner #(
      .WIDTH(W), .NKEYS(NK), .DEB_CYCLES(DEB), .TOGGLE_MASK(MASK)
   ) dut (
      .hwclk    (hwclk),
      .n_rst    (n_rst),
      .pb_raw   (pb_raw),
      .pb_level (pb_level),
      .pb_rise  (pb_rise),
      .pb_fall  (pb_fall),
      .key_valid(key_valid),
      .key_idx  (key_idx),
      .pb_toggle(pb_toggle)
   );

   initial hwclk = 1'b0;
   always #5 hwclk = ~hwclk;

   typedef struct {
      logic [W-1:0] level;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic [W-1:0] tog;
      logic         kv;
      logic [3:0]   kidx;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] raw_v = '0;
   logic         rst_v = 1'b0;

   // Reference model state.
   logic [W-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0, m_tog = '0;
   logic         m_kv = 1'b0;
   logic [3:0]   m_kidx = 4'd0;
   int           run [W];

`ifdef PB_TOGGLE_EN
   localparam bit TOG_ON = 1'b1;
`else
   localparam bit TOG_ON = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model of one clock edge: 2-sample sync delay, then a level is accepted
   // once the synced input has disagreed with it for DEB edges in a row.
   task automatic model_edge();
      logic [W-1:0] old_level, old_rise, s2_old;
      exp_t e;
      bit found;
      old_level = m_level;
      old_rise  = m_rise;
      s2_old    = m_s2;
      if (!rst_v) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
         m_kv = 1'b0; m_kidx = 4'd0;
         for (int i = 0; i < W; i++) run[i] = 0;
      end else begin
         m_kv = 1'b0; m_kidx = 4'd0; found = 1'b0;
         for (int i = 0; i < NK; i++) begin
            if (old_level[i] && !found) begin
               found = 1'b1; m_kv = 1'b1; m_kidx = 4'(i);
            end
         end
         if (TOG_ON) m_tog = m_tog ^ (old_rise & MASK);
         else        m_tog = '0;
         m_s2 = m_s1;
         m_s1 = raw_v;
         for (int i = 0; i < W; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (s2_old[i] != m_level[i]) begin
               run[i]++;
               if (run[i] == DEB) begin
                  m_level[i] = s2_old[i];
                  m_rise[i]  = s2_old[i];
                  m_fall[i]  = ~s2_old[i];
                  run[i]     = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
      end
      e.level = m_level; e.rise = m_rise; e.fall = m_fall;
      e.tog = m_tog; e.kv = m_kv; e.kidx = m_kidx;
      q.push_back(e);
   endtask

   // Drive one cycle; returns just after the edge so callers may sample.
   task automatic step();
      @(negedge hwclk);
      pb_raw = raw_v;
      n_rst  = rst_v;
      model_edge();
      @(posedge hwclk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps until the chosen pulse appears; checks how many edges it took.
   task automatic wait_pulse(input int b, input bit rising, input int exp_lat, input string nm);
      int  n;
      bit  seen;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (rising ? pb_rise[b] : pb_fall[b]) seen = 1'b1;
      end
      chk(nm, 32'(n), 32'(exp_lat));
   endtask

   // Monitor: compare every post-edge output set against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge hwclk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_level", 32'(pb_level), 32'(e.level));
            chk("sb_rise",  32'(pb_rise),  32'(e.rise));
            chk("sb_fall",  32'(pb_fall),  32'(e.fall));
            chk("sb_kv",    32'(key_valid), 32'(e.kv));
            chk("sb_kidx",  32'(key_idx),  32'(e.kidx));
            chk("sb_tog",   32'(pb_toggle), 32'(e.tog));
         end
      end
   end

   initial begin
      bit any_pulse;
      for (int i = 0; i < W; i++) run[i] = 0;
      pb_raw = '0;
      n_rst  = 1'b0;

      // 1. Reset with all inputs high, then release.
      raw_v = 20'hFFFFF; rst_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_level", 32'(pb_level), 32'h0);
         chk("rst_kv", 32'(key_valid), 32'h0);
      end
      rst_v = 1'b1;
      wait_pulse(0, 1'b1, 6, "rst_release_latency");
      chk("rst_release_rise_all", 32'(pb_rise), 32'hFFFFF);
      chk("rst_release_level_all", 32'(pb_level), 32'hFFFFF);
      step();
      chk("rst_release_rise_once", 32'(pb_rise), 32'h0);
      raw_v = '0;
      settle(10);

      // 2. Clean press and release of key 3.
      raw_v[3] = 1'b1;
      wait_pulse(3, 1'b1, 6, "press3_latency");
      step();
      chk("press3_kv", 32'(key_valid), 32'h1);
      chk("press3_kidx", 32'(key_idx), 32'h3);
      raw_v[3] = 1'b0;
      wait_pulse(3, 1'b0, 6, "release3_latency");
      step();
      chk("release3_kv", 32'(key_valid), 32'h0);
      settle(3);

      // 3. Bounce on bit 5: never stable for 4 synced edges.
      any_pulse = 1'b0;
      raw_v[5] = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); any_pulse |= pb_rise[5] | pb_fall[5]; end
      raw_v[5] = 1'b0; step(); any_pulse |= pb_rise[5] | pb_fall[5];
      raw_v[5] = 1'b1;
      for (int i = 0; i < 2; i++) begin step(); any_pulse |= pb_rise[5] | pb_fall[5]; end
      raw_v[5] = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); any_pulse |= pb_rise[5] | pb_fall[5] | pb_level[5]; end
      chk("bounce5_no_activity", 32'(any_pulse), 32'h0);

      // 4. Simultaneous keys 9 and 2: lowest index wins.
      raw_v[9] = 1'b1; raw_v[2] = 1'b1;
      wait_pulse(2, 1'b1, 6, "press2_latency");
      chk("press9_same_cycle", 32'(pb_rise[9]), 32'h1);
      step();
      chk("prio_kidx2", 32'(key_idx), 32'h2);
      raw_v[2] = 1'b0;
      wait_pulse(2, 1'b0, 6, "release2_latency");
      step();
      chk("prio_kidx9", 32'(key_idx), 32'h9);
      raw_v[9] = 1'b0;
      settle(10);

      // 5. Reset in the middle of a debounce on bit 17.
      raw_v[17] = 1'b1;
      any_pulse = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); any_pulse |= pb_rise[17]; end
      rst_v = 1'b0; step(); any_pulse |= pb_rise[17] | pb_level[17];
      chk("midrst_no_pulse", 32'(any_pulse), 32'h0);
      rst_v = 1'b1;
      wait_pulse(17, 1'b1, 6, "midrst_release_latency");
      raw_v[17] = 1'b0;
      settle(10);

      // 6. Toggle behaviour on bit 18 (masked) and bit 17 (unmasked).
      for (int p = 0; p < 2; p++) begin
         raw_v[18] = 1'b1;
         wait_pulse(18, 1'b1, 6, "tog18_press_latency");
         chk("tog18_before", 32'(pb_toggle[18]), (TOG_ON && p == 1) ? 32'h1 : 32'h0);
         step();
         chk("tog18_after", 32'(pb_toggle[18]), (TOG_ON && p == 0) ? 32'h1 : 32'h0);
         raw_v[18] = 1'b0;
         settle(8);
      end
      raw_v[17] = 1'b1;
      wait_pulse(17, 1'b1, 6, "tog17_press_latency");
      step();
      chk("tog17_stays0", 32'(pb_toggle[17]), 32'h0);
      raw_v[17] = 1'b0;
      settle(8);

      // Random phase: sparse flips, bursts, bounces and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0)   raw_v[$urandom_range(0, W-1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0)  raw_v ^= W'($urandom);
         rst_v = ($urandom_range(0, 249) != 0);
         step();
      end
      rst_v = 1'b1;
      settle(2);

      @(negedge hwclk);
      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
